// File: rtl/pattern_pkg.sv
// pattern_pkg: shared encodings for the test-pattern source and future
// raster-walking sink/checker blocks.
//   - PAT_* : pattern select encodings for the mode input
//   - state_t : request/ack handshake states
//   - LFSR_SEED / lfsr_step : pseudo-random pattern seed and step function
package pattern_pkg;

  localparam logic [2:0] PAT_HGRAD = 3'd0;
  localparam logic [2:0] PAT_VGRAD = 3'd1;
  localparam logic [2:0] PAT_CHECK = 3'd2;
  localparam logic [2:0] PAT_CONST = 3'd3;
  localparam logic [2:0] PAT_LFSR  = 3'd4;

  typedef enum logic [1:0] {S_IDLE, S_ACK, S_WAIT} state_t;

  localparam logic [7:0] LFSR_SEED = 8'hA5;

  // Fibonacci LFSR, x^8+x^6+x^5+x^4+1, shifting toward the MSB.
  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

endpackage

// File: rtl/raster_cnt.sv
// raster_cnt: row-major x/y position counter for a WIDTH x HEIGHT raster.
//   clk, xrst   : clock, async active-low reset
//   i_adv       : advance one pixel at the end of this cycle
//   o_x, o_y    : current coordinate
//   o_first     : current coordinate is (0,0)
//   o_last      : current coordinate is (WIDTH-1,HEIGHT-1)
module raster_cnt #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  localparam int XW = $clog2(WIDTH),
  localparam int YW = $clog2(HEIGHT)
) (
  input  logic          clk,
  input  logic          xrst,
  input  logic          i_adv,
  output logic [XW-1:0] o_x,
  output logic [YW-1:0] o_y,
  output logic          o_first,
  output logic          o_last
);

  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic          w_xend;

  assign w_xend  = (r_x == XW'(WIDTH - 1));
  assign o_last  = w_xend && (r_y == YW'(HEIGHT - 1));
  assign o_first = (r_x == '0) && (r_y == '0);
  assign o_x     = r_x;
  assign o_y     = r_y;

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_adv) begin
      if (o_last) begin
        r_x <= '0;
        r_y <= '0;
      end else if (w_xend) begin
        r_x <= '0;
        r_y <= r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pattern_src.sv
// pattern_src: test-pattern pixel source answering a req/ack pixel port.
// One generated pixel per ack, walking a WIDTH x HEIGHT raster row-major.
//   clk, xrst          : clock, async active-low reset
//   snd_req            : pixel request (level)
//   snd_ack            : one-cycle pulse, pixel_out valid
//   pixel_out          : generated pixel, held between acks
//   enable             : gates starting new transfers
//   mode               : pattern select, latched at pixel (0,0)
//   const_v            : constant pattern value, sampled live
//   frame_start/end    : pulse with ack of first/last pixel
//   frame_cnt          : completed frames (wraps)
// Build option: PATTERN_SRC_LFSR_EN adds the LFSR pattern on mode 4;
// without it mode 4 falls back to the constant value.
module pattern_src #(
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480,
  parameter int GAP        = 0,
  parameter int CHECK_LOG2 = 3
) (
  input  logic        clk,
  input  logic        xrst,
  input  logic        snd_req,
  output logic        snd_ack,
  output logic [7:0]  pixel_out,
  input  logic        enable,
  input  logic [2:0]  mode,
  input  logic [7:0]  const_v,
  output logic        frame_start,
  output logic        frame_end,
  output logic [15:0] frame_cnt
);
  import pattern_pkg::*;

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);

  state_t        r_state;
  logic [3:0]    r_wait;
  logic [2:0]    r_mode;
  logic [XW-1:0] w_x;
  logic [YW-1:0] w_y;
  logic          w_first, w_last, w_fire;
  logic [2:0]    w_mode;
  logic [7:0]    w_pix;
  logic          w_chk;

  // The decision to start the next transfer is taken in IDLE or in the
  // final WAIT cycle, so a held request yields one pixel per 2+GAP cycles
  // while acks can never land in back-to-back cycles.
  assign w_fire = snd_req && enable &&
                  ((r_state == S_IDLE) || (r_state == S_WAIT && r_wait == 4'd0));

  // Pixel (0,0) already uses the newly sampled mode.
  assign w_mode = w_first ? mode : r_mode;
  assign w_chk  = 1'(32'(w_x) >> CHECK_LOG2) ^ 1'(32'(w_y) >> CHECK_LOG2);

  raster_cnt #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_raster (
    .clk     (clk),
    .xrst    (xrst),
    .i_adv   (w_fire),
    .o_x     (w_x),
    .o_y     (w_y),
    .o_first (w_first),
    .o_last  (w_last)
  );

`ifdef PATTERN_SRC_LFSR_EN
  logic [7:0] r_lfsr;
  logic [7:0] w_lfsr;
  // Reseed at each frame start so every frame's noise is identical.
  assign w_lfsr = w_first ? LFSR_SEED : r_lfsr;

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst)       r_lfsr <= LFSR_SEED;
    else if (w_fire) r_lfsr <= lfsr_step(w_lfsr);
  end
`endif

  always_comb begin
    w_pix = const_v;
    case (w_mode)
      PAT_HGRAD: w_pix = 8'(w_x);
      PAT_VGRAD: w_pix = 8'(w_y);
      PAT_CHECK: w_pix = w_chk ? 8'hFF : 8'h00;
`ifdef PATTERN_SRC_LFSR_EN
      PAT_LFSR:  w_pix = w_lfsr;
`endif
      default:   w_pix = const_v;
    endcase
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      r_state     <= S_IDLE;
      r_wait      <= '0;
      r_mode      <= '0;
      snd_ack     <= 1'b0;
      pixel_out   <= 8'h00;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      snd_ack     <= w_fire;
      frame_start <= w_fire && w_first;
      frame_end   <= w_fire && w_last;
      if (w_fire) begin
        pixel_out <= w_pix;
        if (w_first) r_mode    <= mode;
        if (w_last)  frame_cnt <= frame_cnt + 16'd1;
      end
      case (r_state)
        S_IDLE: if (w_fire) r_state <= S_ACK;
        S_ACK: begin
          r_state <= S_WAIT;
          r_wait  <= 4'(GAP);
        end
        S_WAIT: begin
          if (r_wait != 4'd0) r_wait  <= r_wait - 4'd1;
          else if (w_fire)    r_state <= S_ACK;
          else                r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_src.sv
// tb_pattern_src: directed bench for pattern_src. DUT A is a 4x2 raster
// with no gap; DUT B is a 4x4 raster with GAP=2. Both use 2-pixel checks.
module tb_pattern_src;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_req, a_en, a_ack, a_fs, a_fe;
  logic [2:0]  a_mode;
  logic [7:0]  a_cv, a_pix;
  logic [15:0] a_fc;
  logic        b_rst, b_req, b_en, b_ack, b_fs, b_fe;
  logic [2:0]  b_mode;
  logic [7:0]  b_cv, b_pix;
  logic [15:0] b_fc;

  pattern_src #(.WIDTH(4), .HEIGHT(2), .GAP(0), .CHECK_LOG2(1)) u_a (
    .clk(clk), .xrst(a_rst), .snd_req(a_req), .snd_ack(a_ack),
    .pixel_out(a_pix), .enable(a_en), .mode(a_mode), .const_v(a_cv),
    .frame_start(a_fs), .frame_end(a_fe), .frame_cnt(a_fc));

  pattern_src #(.WIDTH(4), .HEIGHT(4), .GAP(2), .CHECK_LOG2(1)) u_b (
    .clk(clk), .xrst(b_rst), .snd_req(b_req), .snd_ack(b_ack),
    .pixel_out(b_pix), .enable(b_en), .mode(b_mode), .const_v(b_cv),
    .frame_start(b_fs), .frame_end(b_fe), .frame_cnt(b_fc));

  int n_cmp = 0;
  int n_bad = 0;

  // CHECK pattern for a 4x4 raster with 2-pixel squares, row-major.
  logic [7:0] ck_tab [16] = '{8'h00, 8'h00, 8'hFF, 8'hFF,
                              8'h00, 8'h00, 8'hFF, 8'hFF,
                              8'hFF, 8'hFF, 8'h00, 8'h00,
                              8'hFF, 8'hFF, 8'h00, 8'h00};
  logic [7:0] lf_exp [3];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Step until the selected DUT acks (bounded), then check its pixel.
  task automatic wait_ack(input bit sel, input string tag, input logic [7:0] exp);
    bit seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      tick();
      seen = sel ? b_ack : a_ack;
    end
    chk({tag, " ack"}, 32'(seen), 32'd1);
    if (seen) chk(tag, 32'(sel ? b_pix : a_pix), 32'(exp));
  endtask

  initial begin
    int cnt;
    a_rst = 0; a_req = 0; a_en = 0; a_mode = 0; a_cv = 0;
    b_rst = 0; b_req = 0; b_en = 0; b_mode = 0; b_cv = 0;
    tick(); tick();
    chk("rst ack", 32'(a_ack), 0);
    chk("rst pix", 32'(a_pix), 0);
    chk("rst fs",  32'(a_fs), 0);
    chk("rst fe",  32'(a_fe), 0);
    chk("rst fcnt", 32'(a_fc), 0);

    // HGRAD stream, request held: acks on every other cycle
    a_rst = 1; a_en = 1; a_mode = 0; a_req = 1;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk($sformatf("hg ack c%0d", i), 32'(a_ack), 32'(i % 2 == 0));
      if (i % 2 == 0) begin
        chk($sformatf("hg pix %0d", i / 2), 32'(a_pix), 32'((i / 2) % 4));
        chk($sformatf("hg fs %0d", i / 2), 32'(a_fs), 32'(i == 0));
        chk($sformatf("hg fe %0d", i / 2), 32'(a_fe), 32'(i == 14));
      end
    end
    chk("fcnt 1", 32'(a_fc), 1);

    // pause mid-line at x=2
    wait_ack(0, "f2 x0", 8'd0);
    wait_ack(0, "f2 x1", 8'd1);
    a_en = 0;
    cnt = 0;
    repeat (12) begin
      tick();
      cnt += int'(a_ack);
    end
    chk("paused acks", 32'(cnt), 0);
    a_en = 1;
    wait_ack(0, "resume x2", 8'd2);
    wait_ack(0, "f2 x3y0", 8'd3);
    wait_ack(0, "f2 x0y1", 8'd0);
    wait_ack(0, "f2 x1y1", 8'd1);
    wait_ack(0, "f2 x2y1", 8'd2);
    wait_ack(0, "f2 x3y1", 8'd3);
    chk("f2 fe", 32'(a_fe), 1);
    tick();
    chk("f2 fcnt", 32'(a_fc), 2);

    // async reset in WAIT
    a_rst = 0;
    #1;
    chk("mid rst pix", 32'(a_pix), 0);
    chk("mid rst fcnt", 32'(a_fc), 0);
    a_rst = 1;
    wait_ack(0, "post rst", 8'd0);
    chk("post rst fs", 32'(a_fs), 1);
    chk("post rst fcnt", 32'(a_fc), 0);

    // mode 4: LFSR when built in, constant otherwise
`ifdef PATTERN_SRC_LFSR_EN
    lf_exp = '{8'hA5, 8'h4A, 8'h95};
`else
    lf_exp = '{8'h5A, 8'h5A, 8'h5A};
`endif
    a_rst = 0;
    tick();
    a_mode = 4; a_cv = 8'h5A; a_rst = 1;
    for (int k = 0; k < 3; k++) wait_ack(0, $sformatf("m4 %0d", k), lf_exp[k]);
    a_req = 0;

    // GAP=2 spacing
    b_rst = 1; b_en = 1; b_mode = 1; b_req = 1;
    for (int i = 1; i <= 17; i++) begin
      tick();
      chk($sformatf("gap ack c%0d", i), 32'(b_ack), 32'((i - 1) % 4 == 0));
    end

    // mode change mid-frame only takes effect at the next frame
    b_rst = 0;
    tick();
    b_rst = 1;
    for (int k = 0; k < 16; k++) begin
      wait_ack(1, $sformatf("vg %0d", k), 8'(k / 4));
      if (k == 0)  chk("vg fs", 32'(b_fs), 1);
      if (k == 5)  b_mode = 2;
      if (k == 15) chk("vg fe", 32'(b_fe), 1);
    end
    for (int k = 0; k < 16; k++) wait_ack(1, $sformatf("ck %0d", k), ck_tab[k]);
    chk("b fcnt", 32'(b_fc), 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pattern_src.md
# pattern_src

Test-pattern pixel source that acts as the responding end of the pipeline's req/ack pixel port. It feeds the receive port of `framebuf` in place of an external camera or host. A requester asserts `snd_req`; the block answers with `snd_ack` and one generated 8-bit pixel per transfer, walking a WIDTH x HEIGHT raster in row-major order. It lets the `framebuf` → `adjust_v` → `framebuf` chain run standalone in simulation and on the board.

## Interface
- WIDTH, 640, pixels per line (≥2)
- HEIGHT, 480, lines per frame (≥2)
- GAP, 0, extra idle cycles after each ack (0..15)
- CHECK_LOG2, 3, checkerboard square size is 2^CHECK_LOG2 pixels
- clk  in  1  clock, all logic on rising edge
- xrst  in  1  asynchronous, active-low reset
- snd_req  in  1  pixel request from consumer (level)
- snd_ack  out  1  one-cycle pulse: pixel_out valid this cycle
- pixel_out  out  8  generated pixel
- enable  in  1  gate for new transfers
- mode  in  3  pattern select, sampled at frame start
- const_v  in  8  value for constant pattern
- frame_start  out  1  pulse with ack of pixel (0,0)
- frame_end  out  1  pulse with ack of pixel (WIDTH-1,HEIGHT-1)
- frame_cnt  out  16  completed frames, wraps at 16'hFFFF→0

## Operation
- State machine IDLE → ACK → WAIT → IDLE.
  - IDLE: if snd_req & enable, go to ACK next cycle.
  - ACK: snd_ack=1 for exactly one cycle, pixel_out = pattern(x,y). Counters advance at the end of the cycle. Go to WAIT.
  - WAIT: 1+GAP cycles with snd_ack=0, then IDLE.
- The mandatory WAIT cycle means snd_ack is never high in consecutive cycles. A requester can drop snd_req the cycle it sees the last ack with no overrun.
- Raster order:
  - x increments each ack; at x=WIDTH-1, x wraps to 0 and y increments.
  - At (WIDTH-1, HEIGHT-1), both wrap to 0, frame_end pulses and frame_cnt increments.
- mode_r latches `mode` in the ACK cycle of pixel (0,0) and holds for the whole frame. The pixel (0,0) itself uses the new mode.
- Patterns (x, y are the current coordinates before advance):
  - 0 HGRAD: x[7:0]
  - 1 VGRAD: y[7:0]
  - 2 CHECK: x[CHECK_LOG2] ^ y[CHECK_LOG2] ? 8'hFF : 8'h00
  - 3 CONST: const_v, sampled live each ack
  - 4 LFSR: see Configuration
  - 5–7: as CONST
- Counter widths: x is $clog2(WIDTH) bits, y is $clog2(HEIGHT) bits. Coordinate bits above 7 are ignored for gradients (gradients wrap every 256).
- enable low only blocks the IDLE→ACK transition. A frame in progress pauses and resumes at the same coordinate. No pixel is skipped or repeated.
- snd_req dropping in WAIT or ACK has no effect on the current transfer.

## Timing
- Reset values: snd_ack=0, pixel_out=8'h00, frame_start=0, frame_end=0, frame_cnt=0. State is IDLE, x=y=0, mode_r=0.
- Latency: snd_req sampled high in IDLE in cycle N gives snd_ack in cycle N+1.
- Throughput: one pixel per 2+GAP cycles with snd_req held high.
- pixel_out, snd_ack, frame_start and frame_end are registered, with no combinational path from inputs.
- pixel_out holds its last value when snd_ack=0.
- Reset mid-frame (xrst low at any time) clears everything immediately. The next transfer is pixel (0,0) with frame_start.

## Configuration
- PATTERN_SRC_LFSR_EN defined:
  - mode 4 outputs an 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1.
  - The LFSR is seeded to 8'hA5 on reset and at each frame start; pixel (0,0) = 8'hA5.
  - It steps once per ack.
- Undefined: no LFSR logic; mode 4 behaves as CONST.

## Structure
- Shared package `pattern_pkg` holds:
  - mode encodings PAT_HGRAD=0, PAT_VGRAD=1, PAT_CHECK=2, PAT_CONST=3, PAT_LFSR=4
  - state encoding S_IDLE, S_ACK, S_WAIT
  - LFSR seed constant
- One sub-module, `raster_cnt`: x/y counters with wrap and first/last flags, reusable by future sink/checker blocks.

## Test plan
- Reset, then snd_req held high, WIDTH=4, HEIGHT=2, mode=0 → acks in cycles 1,3,5,…; pixel sequence 0,1,2,3,0,1,2,3; frame_end on the 8th ack; frame_cnt=1.
- GAP=2, snd_req high → ack spacing exactly 4 cycles; snd_ack never high two consecutive cycles.
- mode changed from 1 to 2 mid-frame → current frame continues VGRAD; next frame starts CHECK. With CHECK_LOG2=1: x=2,y=0 → 8'hFF; x=2,y=2 → 8'h00.
- enable low for 10 cycles mid-line at x=2 → no acks; on re-enable the next pixel is x=2 (value 2 in HGRAD).
- xrst pulsed low during WAIT at (3,1) → outputs zero; next ack is pixel 0 with frame_start=1 and frame_cnt=0.
- With PATTERN_SRC_LFSR_EN, mode=4 → first three pixels 8'hA5 then the LFSR's next two states. Without the macro, mode=4 with const_v=8'h5A → all pixels 8'h5A.
